// File: rtl/mips_main_fsm_pkg.sv
// Shared constants for the multicycle MIPS controller:
// opcodes, FSM state encodings and aluOp encodings.
package mips_main_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        HALT    = 4'd12
    } state_t;

    function automatic logic op_known(input logic [5:0] o);
        return (o == OP_RTYPE) || (o == OP_LW) || (o == OP_SW) ||
               (o == OP_BEQ) || (o == OP_ADDI) || (o == OP_J);
    endfunction

endpackage

// File: rtl/mips_main_fsm_outdec.sv
// Combinational state -> control-word table for the main FSM.
// Unlisted and unused state codes drive every control to 0.
module mips_fsm_outdec
    import mips_main_fsm_pkg::*;
(
    input  logic [3:0] state,
    output logic [1:0] aluOp,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSrc,
    output logic       iorD,
    output logic       irWrite,
    output logic       memWrite,
    output logic       regWrite,
    output logic       regDst,
    output logic       memtoReg,
    output logic       pcWrite,
    output logic       branch
);

    // Moore decode of the control word from the current state
    always_comb begin
        aluOp    = ALUOP_ADD;
        aluSrcA  = 1'b0;
        aluSrcB  = 2'b00;
        pcSrc    = 2'b00;
        iorD     = 1'b0;
        irWrite  = 1'b0;
        memWrite = 1'b0;
        regWrite = 1'b0;
        regDst   = 1'b0;
        memtoReg = 1'b0;
        pcWrite  = 1'b0;
        branch   = 1'b0;
        case (state)
            FETCH: begin
                aluSrcB = 2'b01;
                irWrite = 1'b1;
                pcWrite = 1'b1;
            end
            DECODE: aluSrcB = 2'b11;
            MEMADR, ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            MEMRD: iorD = 1'b1;
            MEMWB: begin
                memtoReg = 1'b1;
                regWrite = 1'b1;
            end
            MEMWR: begin
                iorD     = 1'b1;
                memWrite = 1'b1;
            end
            RTYPEEX: begin
                aluSrcA = 1'b1;
                aluOp   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
            end
            BEQEX: begin
                aluSrcA = 1'b1;
                aluOp   = ALUOP_SUB;
                pcSrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIWB: regWrite = 1'b1;
            JEX: begin
                pcSrc   = 2'b10;
                pcWrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_main_fsm.sv
// Multicycle MIPS main controller: state register, next-state
// logic, branch-qualified PC enable and illegal-opcode detect.
module mips_main_fsm
    import mips_main_fsm_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic [1:0] aluOp,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSrc,
    output logic       iorD,
    output logic       irWrite,
    output logic       memWrite,
    output logic       regWrite,
    output logic       regDst,
    output logic       memtoReg,
    output logic       pcEn,
    output logic       illegalOp,
    output logic [3:0] state
);

    state_t cur;
    state_t nxt;
    logic   ir_wr;
    logic   mem_wr;
    logic   reg_wr;
    logic   pc_wr;
    logic   br;

    // State register, asynchronously forced to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= FETCH;
        else       cur <= nxt;
    end

    // Next-state selection from current state and opcode
    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH: nxt = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = RTYPEEX;
                    OP_BEQ:       nxt = BEQEX;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JEX;
                    default:      nxt = ILLEGAL_TRAP ? HALT : FETCH;
                endcase
            end
            MEMADR: begin
                if (op == OP_SW)      nxt = MEMWR;
                else if (op == OP_LW) nxt = MEMRD;
                else                  nxt = FETCH;
            end
            MEMRD:   nxt = MEMWB;
            RTYPEEX: nxt = RTYPEWB;
            ADDIEX:  nxt = ADDIWB;
            HALT:    nxt = HALT;
            default: nxt = FETCH;
        endcase
    end

    mips_fsm_outdec u_outdec (
        .state    (cur),
        .aluOp    (aluOp),
        .aluSrcA  (aluSrcA),
        .aluSrcB  (aluSrcB),
        .pcSrc    (pcSrc),
        .iorD     (iorD),
        .irWrite  (ir_wr),
        .memWrite (mem_wr),
        .regWrite (reg_wr),
        .regDst   (regDst),
        .memtoReg (memtoReg),
        .pcWrite  (pc_wr),
        .branch   (br)
    );

    // Enables are suppressed while reset is held so no write
    // can slip through before the state register settles.
    assign irWrite   = ir_wr & ~reset;
    assign memWrite  = mem_wr & ~reset;
    assign regWrite  = reg_wr & ~reset;
    assign pcEn      = (pc_wr | (br & zero)) & ~reset;
    assign illegalOp = (cur == DECODE) & ~op_known(op) & ~reset;
    assign state     = cur;

endmodule

// File: doc/mips_main_fsm.md
Name: mips_main_fsm

Overview:
Multicycle MIPS main controller. It decodes the 6-bit opcode from the instruction register and steps through the fetch/decode/execute/memory/writeback states. Each cycle it drives the datapath enables and mux selects, plus the 2-bit aluOp consumed by the ALU decoder. It sits beside the ALU decoder inside the controller and is the producer side of the aluOp interface.

Parameters:
ILLEGAL_TRAP, 0, 0 = an illegal opcode returns to FETCH; 1 = an illegal opcode parks in HALT until reset.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
op  input  6  opcode field instr[31:26], held stable by the IR from the end of FETCH
zero  input  1  ALU zero flag
aluOp  output  2  00 add, 01 sub, 10 use funct
aluSrcA  output  1  0 = PC, 1 = regA
aluSrcB  output  2  00 regB, 01 const 4, 10 signimm, 11 signimm<<2
pcSrc  output  2  00 ALU result, 01 ALUOut, 10 jump target
iorD  output  1  memory address: 0 = PC, 1 = ALUOut
irWrite  output  1  instruction register load
memWrite  output  1  memory write strobe
regWrite  output  1  register file write
regDst  output  1  0 = rt, 1 = rd
memtoReg  output  1  0 = ALUOut, 1 = data register
pcEn  output  1  pcWrite | (branch & zero)
illegalOp  output  1  one-cycle pulse on an unknown opcode
state  output  4  current state, for debug

Behaviour:
- State register: 4 bits. Encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, HALT 12.
- Reset: asynchronous, sets state = FETCH. While reset is high, irWrite, pcEn, regWrite, memWrite and illegalOp are forced to 0; the mux selects show FETCH values.
- Transitions:
  - FETCH -> DECODE.
  - DECODE on op: lw 100011 or sw 101011 -> MEMADR; 000000 -> RTYPEEX; beq 000100 -> BEQEX; addi 001000 -> ADDIEX; j 000010 -> JEX; any other op -> FETCH (ILLEGAL_TRAP = 0) or HALT (ILLEGAL_TRAP = 1).
  - MEMADR: lw -> MEMRD, sw -> MEMWR, using op sampled in MEMADR.
  - MEMRD -> MEMWB; RTYPEEX -> RTYPEWB; ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX -> FETCH.
  - HALT -> HALT.
  - Codes 13-15 -> FETCH, with all enables 0.
- Outputs are Moore, decoded from state; pcEn additionally uses zero combinationally. Any output not listed below is 0.
  - FETCH: iorD 0, aluSrcA 0, aluSrcB 01, aluOp 00, pcSrc 00, irWrite 1, pcWrite 1.
  - DECODE: aluSrcA 0, aluSrcB 11, aluOp 00.
  - MEMADR and ADDIEX: aluSrcA 1, aluSrcB 10, aluOp 00.
  - MEMRD: iorD 1.
  - MEMWB: regDst 0, memtoReg 1, regWrite 1.
  - MEMWR: iorD 1, memWrite 1.
  - RTYPEEX: aluSrcA 1, aluSrcB 00, aluOp 10.
  - RTYPEWB: regDst 1, memtoReg 0, regWrite 1.
  - BEQEX: aluSrcA 1, aluSrcB 00, aluOp 01, pcSrc 01, branch 1.
  - ADDIWB: regDst 0, memtoReg 0, regWrite 1.
  - JEX: pcSrc 10, pcWrite 1.
  - HALT: everything 0.
- illegalOp is high for exactly the DECODE cycle that sees an unknown op.
- Latency in cycles, FETCH included: lw 5, sw 4, R-type 4, beq 3, addi 4, j 3.
- Write enables are never asserted in two consecutive states except pcWrite across JEX -> FETCH, which is legal.
- Reset asserted mid-instruction: the state returns to FETCH immediately and no writeback completes.

Decomposition:
- Shared package: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), state encodings, and aluOp encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT). The ALU decoder imports the same aluOp constants.
- One sub-module is natural: mips_fsm_outdec, a purely combinational state -> control-word table. The top holds the state register, next-state logic and pcEn.

Test Plan:
- Reset held, then released with op = 100011 (lw): states 0,1,2,3,4,0. regWrite = 1 and memtoReg = 1 only in cycle 5. irWrite = 1 only in cycle 1.
- op = 101011 (sw): states 0,1,2,5,0. memWrite = 1 and iorD = 1 in cycle 4 only. regWrite is never 1.
- op = 000100 (beq) with zero = 1, then repeated with zero = 0: in BEQEX, aluOp = 01 and pcSrc = 01; pcEn = 1 in the first case and 0 in the second; 3 cycles total.
- op = 000000 (R-type), then 001000 (addi): RTYPEEX has aluOp = 10; RTYPEWB has regDst = 1. ADDIEX has aluSrcB = 10 and aluOp = 00; ADDIWB has regDst = 0.
- op = 111111 with ILLEGAL_TRAP = 0: illegalOp pulses 1 cycle in DECODE, next state FETCH. With ILLEGAL_TRAP = 1: state goes to 12, all enables 0 for 10+ cycles, and reset recovers to FETCH.
- Reset asserted asynchronously mid-MEMRD during a lw: state = 0 without waiting for a clock edge. memWrite, regWrite and pcEn are 0 throughout reset. The next instruction runs normally.
